// File: rtl/sw_debounce_if.sv
// Switch-conditioning bundle: raw pins in; clean level, edge pulses and zero flag out.
// Latency: none. The interface is wiring only.
// Backpressure: none. Every signal is a level or a single-cycle pulse.
interface sw_debounce_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_clean;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             sw_changed;
    logic             sw_zero;

    modport master (
        output sw_raw,
        input  sw_clean, sw_rise, sw_fall, sw_changed, sw_zero
    );

    modport slave (
        input  sw_raw,
        output sw_clean, sw_rise, sw_fall, sw_changed, sw_zero
    );
endinterface

// File: rtl/sw_debounce.sv
// Switch debouncer: synchronizes each bit, then requires DEBOUNCE_CYCLES stable cycles per bit.
// Latency: 2+DEBOUNCE_CYCLES cycles, or 3+DEBOUNCE_CYCLES when SW_DEBOUNCE_SYNC3_EN is defined.
// Backpressure: none. Pulses are single-cycle and are never held.
module sw_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    sw_debounce_if.slave    sw_if
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
`ifdef SW_DEBOUNCE_SYNC3_EN
    localparam int SYNC_N = 3;
`else
    localparam int SYNC_N = 2;
`endif
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_N-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]             clean_q, clean_d;
    logic [WIDTH-1:0]             rise_q, rise_d;
    logic [WIDTH-1:0]             fall_q, fall_d;
    logic                         changed_q, changed_d;
    logic [WIDTH-1:0]             sync_last;

    assign sync_last = sync_q[SYNC_N-1];

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = sw_if.sw_raw;
        for (int k = 1; k < SYNC_N; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // Any cycle where the synchronized input agrees with the clean level restarts the count.
    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync_last[i] == clean_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                clean_d[i] = sync_last[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        rise_d    = clean_d & ~clean_q;
        fall_d    = ~clean_d & clean_q;
        changed_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            clean_q   <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            clean_q   <= clean_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign sw_if.sw_clean   = clean_q;
    assign sw_if.sw_rise    = rise_q;
    assign sw_if.sw_fall    = fall_q;
    assign sw_if.sw_changed = changed_q;
    assign sw_if.sw_zero    = ~|clean_q;
endmodule
